eea_binary_inv: RTL and testbench

- Parametrised modular inverse / modular division unit for the ECC datapath, using the binary extended Euclidean algorithm.
- Computes x^-1 mod p, or y·x^-1 mod p in division mode.
- Full operand reduction is built in, so arbitrary inputs are accepted. Run time is bounded and linear in WIDTH.
- Keeps the go/done/failure handshake used by the ECC point-arithmetic controllers.

---
 rtl/eea_binary_inv.sv | 144 ++++++++++++++
 tb/tb_eea_binary_inv.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/eea_binary_inv.sv
// eea_binary_inv: modular inverse x^-1 mod p (or y*x^-1 mod p) via the binary extended Euclidean algorithm
// Ports:
//   i_clk       clock, rising edge
//   i_reset     asynchronous active-high reset
//   i_go        start request, sampled in IDLE; must fall to leave DONE
//   i_div_mode  0: inverse, 1: division y/x mod p (sampled with i_go)
//   i_x, i_y    operands, any value (reduced mod p internally)
//   i_p         modulus, must be odd and >= 3
//   o_x_inv     result, 0 on failure, held until the next accepted go
//   o_done      high while in DONE
//   o_failure   valid with o_done: no inverse, illegal p or watchdog
//   o_busy      high in every state except IDLE
module eea_binary_inv #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_go,
    input  logic             i_div_mode,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_p,
    output logic [WIDTH-1:0] o_x_inv,
    output logic             o_done,
    output logic             o_failure,
    output logic             o_busy
);
    localparam int CW     = $clog2(WIDTH);
    localparam int WD_MAX = 4 * WIDTH + 2;
    localparam int WDW    = $clog2(WD_MAX + 1) + 1;

    typedef enum logic [2:0] {S_IDLE, S_REDX, S_REDY, S_INIT, S_LOOP, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sh, r_y, r_p, r_red, r_xr, r_yr;
    logic [WIDTH-1:0] r_u, r_v, r_x1, r_x2, r_x_inv;
    logic [CW-1:0]    r_cnt;
    logic [WDW-1:0]   r_wd;
    logic             r_div, r_fail;

    logic             w_p_bad, w_red_last, w_u1, w_v1, w_zero, w_wd_exp, w_stop;
    logic [WIDTH:0]   w_red_cat, w_x1_sum, w_x2_sum;
    logic [WIDTH-1:0] w_red_nxt, w_x1_h, w_x2_h, w_d12, w_d21;

    assign w_p_bad    = ~i_p[0] | (i_p < WIDTH'(3));
    assign w_red_last = r_cnt == CW'(WIDTH - 1);
    // r < p before the shift, so {r,bit} < 2p and one conditional subtract restores r < p
    assign w_red_cat  = {r_red, r_sh[WIDTH-1]};
    assign w_red_nxt  = WIDTH'(w_red_cat >= {1'b0, r_p} ? w_red_cat - {1'b0, r_p} : w_red_cat);
    assign w_u1       = r_u == WIDTH'(1);
    assign w_v1       = r_v == WIDTH'(1);
    assign w_zero     = (r_u == '0) | (r_v == '0);
    assign w_wd_exp   = r_wd >= WDW'(WD_MAX);
    assign w_stop     = w_u1 | w_v1 | w_zero | w_wd_exp;
    // odd x < p: x+p is even and needs one extra bit before halving
    assign w_x1_sum   = {1'b0, r_x1} + {1'b0, r_p};
    assign w_x2_sum   = {1'b0, r_x2} + {1'b0, r_p};
    assign w_x1_h     = r_x1[0] ? WIDTH'(w_x1_sum >> 1) : r_x1 >> 1;
    assign w_x2_h     = r_x2[0] ? WIDTH'(w_x2_sum >> 1) : r_x2 >> 1;
    // modular wrap in WIDTH bits yields the correct residue in [0, p-1]
    assign w_d12      = r_x1 >= r_x2 ? r_x1 - r_x2 : r_x1 - r_x2 + r_p;
    assign w_d21      = r_x2 >= r_x1 ? r_x2 - r_x1 : r_x2 - r_x1 + r_p;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = i_go ? (w_p_bad ? S_DONE : S_REDX) : S_IDLE;
            S_REDX:  w_state_nxt = w_red_last ? (r_div ? S_REDY : S_INIT) : S_REDX;
            S_REDY:  w_state_nxt = w_red_last ? S_INIT : S_REDY;
            S_INIT:  w_state_nxt = r_xr == '0 ? S_DONE : S_LOOP;
            S_LOOP:  w_state_nxt = w_stop ? S_DONE : S_LOOP;
            S_DONE:  w_state_nxt = i_go ? S_DONE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy    = r_state != S_IDLE;
        o_done    = r_state == S_DONE;
        o_failure = (r_state == S_DONE) & r_fail;
        o_x_inv   = r_x_inv;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sh <= '0; r_y <= '0; r_p <= '0; r_red <= '0; r_xr <= '0; r_yr <= '0;
            r_u <= '0; r_v <= '0; r_x1 <= '0; r_x2 <= '0; r_x_inv <= '0;
            r_cnt <= '0; r_wd <= '0; r_div <= 1'b0; r_fail <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_go) begin
                    r_sh    <= i_x;
                    r_y     <= i_y;
                    r_p     <= i_p;
                    r_div   <= i_div_mode;
                    r_red   <= '0;
                    r_cnt   <= '0;
                    r_x_inv <= '0;
                    r_fail  <= w_p_bad;
                end
                S_REDX, S_REDY: begin
                    r_red <= w_red_last ? '0 : w_red_nxt;
                    r_sh  <= w_red_last ? r_y : r_sh << 1;
                    r_cnt <= w_red_last ? '0 : r_cnt + CW'(1);
                    if (w_red_last && r_state == S_REDX) r_xr <= w_red_nxt;
                    if (w_red_last && r_state == S_REDY) r_yr <= w_red_nxt;
                end
                S_INIT: begin
                    r_u    <= r_xr;
                    r_v    <= r_p;
                    r_x1   <= r_div ? r_yr : WIDTH'(1);
                    r_x2   <= '0;
                    r_wd   <= '0;
                    r_fail <= r_xr == '0;
                end
                S_LOOP: begin
                    r_wd <= r_wd + WDW'(1);
                    if (w_u1) r_x_inv <= r_x1;
                    else if (w_v1) r_x_inv <= r_x2;
                    else if (w_zero | w_wd_exp) r_fail <= 1'b1;
                    else if (!r_u[0]) begin
                        r_u  <= r_u >> 1;
                        r_x1 <= w_x1_h;
                    end else if (!r_v[0]) begin
                        r_v  <= r_v >> 1;
                        r_x2 <= w_x2_h;
                    end else if (r_u >= r_v) begin
                        r_u  <= r_u - r_v;
                        r_x1 <= w_d12;
                    end else begin
                        r_v  <= r_v - r_u;
                        r_x2 <= w_d21;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_eea_binary_inv.sv
// tb_eea_binary_inv: directed-vector bench for eea_binary_inv at WIDTH 64 and 256
module tb_eea_binary_inv;
    localparam int WS = 64;
    localparam int WL = 256;
    localparam logic [WL-1:0] P64  = 256'hFFFF_FFFF_FFFF_FFC5;
    localparam logic [WL-1:0] P256 = 256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

    logic          clk = 1'b0, rst = 1'b1, go = 1'b0, div = 1'b0, sel = 1'b0;
    logic [WL-1:0] ax = '0, ay = '0, ap = '0;
    logic [WS-1:0] s_inv;
    logic [WL-1:0] l_inv, o_inv;
    logic          s_done, s_fail, s_busy, l_done, l_fail, l_busy, o_done, o_fail, o_busy;
    int            n_vec = 0, n_bad = 0;
    logic [WL-1:0] r_inv;
    logic          r_fail;
    int            r_lat, lat_inv;
    logic [2*WL-1:0] prod;

    always #5 clk = ~clk;

    eea_binary_inv #(.WIDTH(WS)) dut_s (
        .i_clk(clk), .i_reset(rst), .i_go(go & ~sel), .i_div_mode(div),
        .i_x(ax[WS-1:0]), .i_y(ay[WS-1:0]), .i_p(ap[WS-1:0]),
        .o_x_inv(s_inv), .o_done(s_done), .o_failure(s_fail), .o_busy(s_busy)
    );

    eea_binary_inv #(.WIDTH(WL)) dut_l (
        .i_clk(clk), .i_reset(rst), .i_go(go & sel), .i_div_mode(div),
        .i_x(ax), .i_y(ay), .i_p(ap),
        .o_x_inv(l_inv), .o_done(l_done), .o_failure(l_fail), .o_busy(l_busy)
    );

    assign o_inv  = sel ? l_inv : {{(WL-WS){1'b0}}, s_inv};
    assign o_done = sel ? l_done : s_done;
    assign o_fail = sel ? l_fail : s_fail;
    assign o_busy = sel ? l_busy : s_busy;

    task automatic check(input string tag, input logic [WL-1:0] got, input logic [WL-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // mode 0: one-cycle go pulse, 1: hold go after done, 2: toggle go while busy
    task automatic run(input string tag, input logic s, input logic dm, input logic [WL-1:0] x,
                       input logic [WL-1:0] y, input logic [WL-1:0] p, input int mode,
                       input logic known, input logic [WL-1:0] e_inv, input logic e_fail);
        @(negedge clk);
        sel = s; div = dm; ax = x; ay = y; ap = p; go = 1'b1;
        @(posedge clk); #1;
        if (mode != 1) go = 1'b0;
        r_lat = 1;
        while (!o_done && r_lat < 3000) begin
            @(posedge clk); #1;
            r_lat++;
            if (mode == 2) go = ~go;
        end
        check({tag, "_done"}, WL'(o_done), WL'(1));
        r_inv  = o_inv;
        r_fail = o_fail;
        if (known) begin
            check({tag, "_inv"}, o_inv, e_inv);
            check({tag, "_fail"}, WL'(o_fail), WL'(e_fail));
        end
        if (mode == 1) begin
            repeat (3) @(posedge clk);
            #1;
            check({tag, "_hold_done"}, WL'(o_done), WL'(1));
            check({tag, "_hold_inv"}, o_inv, e_inv);
        end
        go = 1'b0;
        @(posedge clk); #1;
        check({tag, "_idle_done"}, WL'(o_done), WL'(0));
        check({tag, "_idle_busy"}, WL'(o_busy), WL'(0));
        check({tag, "_idle_fail"}, WL'(o_fail), WL'(0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", WL'(s_done), WL'(0));
        check("rst_busy", WL'(s_busy), WL'(0));
        check("rst_fail", WL'(s_fail), WL'(0));
        check("rst_inv", WL'(s_inv), WL'(0));
        @(negedge clk);
        rst = 1'b0;

        run("inv3_7", 0, 0, 3, 0, 7, 0, 1, 5, 0);
        lat_inv = r_lat;
        run("div9_3_7", 0, 1, 3, 9, 7, 0, 1, 3, 0);
        check("div_extra_lat", WL'(r_lat - lat_inv), WL'(WS));
        run("inv10_7", 0, 0, 10, 0, 7, 0, 1, 5, 0);
        run("div16_3_7", 0, 1, 3, 16, 7, 0, 1, 3, 0);
        run("div0_3_7", 0, 1, 3, 0, 7, 0, 1, 0, 0);
        run("inv1_7", 0, 0, 1, 0, 7, 0, 1, 1, 0);
        run("inv2_3", 0, 0, 2, 0, 3, 0, 1, 2, 0);
        run("invff_7", 0, 0, 256'hFFFF_FFFF_FFFF_FFFF, 0, 7, 0, 1, 1, 0);
        run("inv2_p64", 0, 0, 2, 0, P64, 0, 1, 256'h7FFF_FFFF_FFFF_FFE3, 0);
        run("invm1_p64", 0, 0, P64 - 1, 0, P64, 0, 1, P64 - 1, 0);
        run("inv2_pmax", 0, 0, 2, 0, 256'hFFFF_FFFF_FFFF_FFFF, 0, 1, 256'h8000_0000_0000_0000, 0);
        run("invp_pmax", 0, 0, 256'hFFFF_FFFF_FFFF_FFFF, 0, 256'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 1);
        run("inv14_7", 0, 0, 14, 0, 7, 0, 1, 0, 1);
        run("inv0_7", 0, 0, 0, 0, 7, 0, 1, 0, 1);
        run("inv6_9", 0, 0, 6, 0, 9, 0, 1, 0, 1);
        run("p8", 0, 0, 3, 0, 8, 0, 1, 0, 1);
        check("p8_lat", WL'(r_lat), WL'(1));
        run("p1", 0, 0, 3, 0, 1, 0, 1, 0, 1);
        check("p1_lat", WL'(r_lat), WL'(1));
        run("hold", 0, 0, 3, 0, 7, 1, 1, 5, 0);
        run("toggle", 0, 0, 2, 0, P64, 2, 1, 256'h7FFF_FFFF_FFFF_FFE3, 0);

        run("w_inv2", 1, 0, 2, 0, P256, 0, 1,
            256'h7FFFFFFF_80000000_80000000_00000000_00000000_80000000_00000000_00000000, 0);
        for (int i = 0; i < 12; i++) begin
            logic [WL-1:0] rx;
            for (int k = 0; k < 8; k++) rx[k*32 +: 32] = $urandom;
            run("rnd", 1, 0, rx, 0, P256, 0, 0, 0, 0);
            prod = ({{WL{1'b0}}, rx} * {{WL{1'b0}}, r_inv}) % {{WL{1'b0}}, P256};
            check("rnd_mod", WL'(prod), WL'(1));
            check("rnd_fail", WL'(r_fail), WL'(0));
            check("rnd_lat_bound", WL'(r_lat <= 5 * WL + 5), WL'(1));
        end

        @(negedge clk);
        sel = 0; div = 0; ax = 256'h1234_5678_9ABC_DEF1; ap = P64; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (70) @(posedge clk);
        #3;
        check("pre_rst_busy", WL'(s_busy), WL'(1));
        rst = 1'b1;
        #1;
        check("async_rst_busy", WL'(s_busy), WL'(0));
        check("async_rst_done", WL'(s_done), WL'(0));
        check("async_rst_fail", WL'(s_fail), WL'(0));
        check("async_rst_inv", WL'(s_inv), WL'(0));
        @(negedge clk);
        rst = 1'b0;
        run("post_rst", 0, 0, 3, 0, 7, 0, 1, 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
